preif_pc_ctrl: RTL and testbench

Fetch-address sequencer in front of the IF stage of the single-issue pipeline. Owns the architectural fetch PC register. Arbitrates between exception entry, ertn return, ID-stage branch redirects and sequential PC+4. Buffers branch redirects that arrive while IF is stalled so they are never lost, and inserts a one-cycle fetch bubble after an exception or ertn so the synchronous instruction RAM read realigns with the new stream.

---
 rtl/preif_pc_ctrl_if.sv | 30 +++
 rtl/preif_pc_ctrl.sv | 115 +++++++++++
 tb/tb_preif_pc_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/preif_pc_ctrl_if.sv
// Fetch-request bundle between the pre-IF PC sequencer and its neighbours.
// The slave modport is the sequencer; the master modport drives the redirects and sees the fetch PC.
interface preif_pc_ctrl_if #(
    parameter int PC_W = 32
);
    logic            if_allowin_i;
    logic            branch_flag_i;
    logic [PC_W-1:0] branch_pc_i;
    logic            excep_en_i;
    logic [PC_W-1:0] excep_entry_pc_i;
    logic            ertn_en_i;
    logic [PC_W-1:0] ertn_pc_i;
    logic [PC_W-1:0] pc_o;
    logic            preif_to_if_valid_o;
    logic            redirect_flush_o;
    logic            br_pending_o;
    logic            adef_o;

    modport master (
        output if_allowin_i, branch_flag_i, branch_pc_i,
               excep_en_i, excep_entry_pc_i, ertn_en_i, ertn_pc_i,
        input  pc_o, preif_to_if_valid_o, redirect_flush_o, br_pending_o, adef_o
    );

    modport slave (
        input  if_allowin_i, branch_flag_i, branch_pc_i,
               excep_en_i, excep_entry_pc_i, ertn_en_i, ertn_pc_i,
        output pc_o, preif_to_if_valid_o, redirect_flush_o, br_pending_o, adef_o
    );
endinterface

// File: rtl/preif_pc_ctrl.sv
// Pre-IF fetch PC sequencer: exception/ertn/branch/sequential arbitration with stalled-branch buffering.
// Optional misaligned-fetch flag enabled by defining PRECTRL_ALIGN_CHECK_EN.
module preif_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000,
    parameter int          PC_W     = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    preif_pc_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);
    localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;
    logic            flush_q, flush_d;
    logic            valid;
    logic            accept;
    logic            pending;

    // State register: every output is either a register or a decode of the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= PC_INIT;
            pend_pc_q <= PC_INIT;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            flush_q   <= flush_d;
        end
    end

    // Next-state/next-PC: exception beats ertn beats branch; a stalled branch is parked in pend_pc.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        flush_d   = 1'b0;
        if (bus.excep_en_i) begin
            pc_d    = bus.excep_entry_pc_i;
            state_d = FLUSH;
            flush_d = 1'b1;
        end else if (bus.ertn_en_i) begin
            pc_d    = bus.ertn_pc_i;
            state_d = FLUSH;
            flush_d = 1'b1;
        end else if (bus.branch_flag_i) begin
            if (accept) begin
                pc_d    = bus.branch_pc_i;
                state_d = RUN;
            end else begin
                pend_pc_d = bus.branch_pc_i;
                state_d   = HOLD;
            end
        end else if (accept) begin
            pc_d    = (state_q == HOLD) ? pend_pc_q : pc_q + PC_STEP;
            state_d = RUN;
        end else if (state_q == BOOT || state_q == FLUSH) begin
            state_d = RUN;
        end
    end

    // Output decode from the registered state only.
    always_comb begin
        valid   = 1'b0;
        pending = 1'b0;
        case (state_q)
            RUN:     valid = 1'b1;
            HOLD: begin
                valid   = 1'b1;
                pending = 1'b1;
            end
            default: valid = 1'b0;
        endcase
        accept = valid & bus.if_allowin_i;
    end

    assign bus.pc_o                = pc_q;
    assign bus.preif_to_if_valid_o = valid;
    assign bus.redirect_flush_o    = flush_q;
    assign bus.br_pending_o        = pending;

`ifdef PRECTRL_ALIGN_CHECK_EN
    logic adef_q;
    logic valid_d;

    // Flag computed from the next PC/state so it lines up with pc_q; the PC itself is left untouched.
    assign valid_d = (state_d == RUN) || (state_d == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adef_q <= 1'b0;
        end else begin
            adef_q <= valid_d & (pc_d[1:0] != 2'b00);
        end
    end

    assign bus.adef_o = adef_q;
`else
    assign bus.adef_o = 1'b0;
`endif

endmodule

// File: tb/tb_preif_pc_ctrl.sv
// Directed self-checking bench for preif_pc_ctrl; expected PCs are hand-computed constants.
module tb_preif_pc_ctrl;

    localparam logic [31:0] RST_PC = 32'h1C00_0000;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic exp_adef;

    preif_pc_ctrl_if #(.PC_W(32)) bus ();

    preif_pc_ctrl #(.RESET_PC(RST_PC), .PC_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.branch_flag_i    = 1'b0;
        bus.branch_pc_i      = 32'h0;
        bus.excep_en_i       = 1'b0;
        bus.excep_entry_pc_i = 32'h0;
        bus.ertn_en_i        = 1'b0;
        bus.ertn_pc_i        = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.if_allowin_i = 1'b1;
        clear_inputs();
        tick();
        tick();
        checks++;
        if (bus.pc_o !== RST_PC) begin
            errors++;
            $display("[TB] FAIL reset_pc got %h want %h", bus.pc_o, RST_PC);
        end
        checks++;
        if ({bus.preif_to_if_valid_o, bus.redirect_flush_o, bus.br_pending_o, bus.adef_o} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b want 0000",
                     {bus.preif_to_if_valid_o, bus.redirect_flush_o, bus.br_pending_o, bus.adef_o});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.preif_to_if_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL boot_valid got %b want 0", bus.preif_to_if_valid_o);
        end
        tick();
        checks++;
        if (bus.pc_o !== 32'h1C00_0000 || bus.preif_to_if_valid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_fetch got %h/%b want 1c000000/1", bus.pc_o, bus.preif_to_if_valid_o);
        end
        tick();
        checks++;
        if (bus.pc_o !== 32'h1C00_0004) begin
            errors++;
            $display("[TB] FAIL seq_pc4 got %h want 1c000004", bus.pc_o);
        end
        tick();
        checks++;
        if (bus.pc_o !== 32'h1C00_0008) begin
            errors++;
            $display("[TB] FAIL seq_pc8 got %h want 1c000008", bus.pc_o);
        end
    endtask

    task automatic test_branch_accept();
        bus.branch_flag_i = 1'b1;
        bus.branch_pc_i   = 32'h1C00_0100;
        tick();
        clear_inputs();
        checks++;
        if (bus.pc_o !== 32'h1C00_0100 || bus.redirect_flush_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL branch_accept got %h/flush %b want 1c000100/0", bus.pc_o, bus.redirect_flush_o);
        end
        tick();
        checks++;
        if (bus.pc_o !== 32'h1C00_0104) begin
            errors++;
            $display("[TB] FAIL branch_seq got %h want 1c000104", bus.pc_o);
        end
    endtask

    task automatic test_branch_stall();
        bus.if_allowin_i  = 1'b0;
        bus.branch_flag_i = 1'b1;
        bus.branch_pc_i   = 32'h1C00_0200;
        tick();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.pc_o !== 32'h1C00_0104 || bus.br_pending_o !== 1'b1 || bus.preif_to_if_valid_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d] got %h/pend %b/valid %b want 1c000104/1/1",
                         i, bus.pc_o, bus.br_pending_o, bus.preif_to_if_valid_o);
            end
            if (i < 2) tick();
        end
        bus.if_allowin_i = 1'b1;
        tick();
        checks++;
        if (bus.pc_o !== 32'h1C00_0200 || bus.br_pending_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_apply got %h/pend %b want 1c000200/0", bus.pc_o, bus.br_pending_o);
        end
        tick();
        checks++;
        if (bus.pc_o !== 32'h1C00_0204) begin
            errors++;
            $display("[TB] FAIL stall_seq got %h want 1c000204", bus.pc_o);
        end
    endtask

    task automatic test_exception();
        // build up a pending branch first so the exception must clear it
        bus.if_allowin_i  = 1'b0;
        bus.branch_flag_i = 1'b1;
        bus.branch_pc_i   = 32'h1C00_0300;
        tick();
        checks++;
        if (bus.br_pending_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL excep_prepend got %b want 1", bus.br_pending_o);
        end
        bus.branch_pc_i      = 32'h1C00_0400;
        bus.excep_en_i       = 1'b1;
        bus.excep_entry_pc_i = 32'h1C00_8000;
        bus.ertn_en_i        = 1'b1;
        bus.ertn_pc_i        = 32'h1C00_0040;
        tick();
        clear_inputs();
        checks++;
        if (bus.pc_o !== 32'h1C00_8000) begin
            errors++;
            $display("[TB] FAIL excep_pc got %h want 1c008000", bus.pc_o);
        end
        checks++;
        if ({bus.preif_to_if_valid_o, bus.redirect_flush_o, bus.br_pending_o} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL excep_flags got %b want 010",
                     {bus.preif_to_if_valid_o, bus.redirect_flush_o, bus.br_pending_o});
        end
        bus.if_allowin_i = 1'b1;
        tick();
        checks++;
        if (bus.pc_o !== 32'h1C00_8000 || bus.preif_to_if_valid_o !== 1'b1 || bus.redirect_flush_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL excep_resume got %h/valid %b/flush %b want 1c008000/1/0",
                     bus.pc_o, bus.preif_to_if_valid_o, bus.redirect_flush_o);
        end
        tick();
        checks++;
        if (bus.pc_o !== 32'h1C00_8004) begin
            errors++;
            $display("[TB] FAIL excep_seq got %h want 1c008004", bus.pc_o);
        end
    endtask

    task automatic test_ertn();
        bus.ertn_en_i = 1'b1;
        bus.ertn_pc_i = 32'h1C00_0040;
        tick();
        clear_inputs();
        checks++;
        if (bus.pc_o !== 32'h1C00_0040 || bus.preif_to_if_valid_o !== 1'b0 || bus.redirect_flush_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ertn_redirect got %h/valid %b/flush %b want 1c000040/0/1",
                     bus.pc_o, bus.preif_to_if_valid_o, bus.redirect_flush_o);
        end
        tick();
        tick();
        checks++;
        if (bus.pc_o !== 32'h1C00_0044 || bus.redirect_flush_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ertn_seq got %h/flush %b want 1c000044/0", bus.pc_o, bus.redirect_flush_o);
        end
    endtask

    task automatic test_wrap();
        bus.branch_flag_i = 1'b1;
        bus.branch_pc_i   = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        checks++;
        if (bus.pc_o !== 32'hFFFF_FFFC) begin
            errors++;
            $display("[TB] FAIL wrap_setup got %h want fffffffc", bus.pc_o);
        end
        tick();
        checks++;
        if (bus.pc_o !== 32'h0000_0000 || bus.preif_to_if_valid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_pc got %h/valid %b want 00000000/1", bus.pc_o, bus.preif_to_if_valid_o);
        end
    endtask

    task automatic test_adef();
`ifdef PRECTRL_ALIGN_CHECK_EN
        exp_adef = 1'b1;
`else
        exp_adef = 1'b0;
`endif
        bus.branch_flag_i = 1'b1;
        bus.branch_pc_i   = 32'h1C00_0102;
        tick();
        clear_inputs();
        checks++;
        if (bus.pc_o !== 32'h1C00_0102 || bus.adef_o !== exp_adef) begin
            errors++;
            $display("[TB] FAIL adef_misaligned got %h/adef %b want 1c000102/%b", bus.pc_o, bus.adef_o, exp_adef);
        end
        bus.branch_flag_i = 1'b1;
        bus.branch_pc_i   = 32'h1C00_0100;
        tick();
        clear_inputs();
        checks++;
        if (bus.adef_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL adef_aligned got %b want 0", bus.adef_o);
        end
    endtask

    task automatic test_async_reset();
        bus.if_allowin_i  = 1'b0;
        bus.branch_flag_i = 1'b1;
        bus.branch_pc_i   = 32'h1C00_0500;
        tick();
        clear_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.pc_o !== RST_PC || bus.br_pending_o !== 1'b0 || bus.preif_to_if_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset got %h/pend %b/valid %b want 1c000000/0/0",
                     bus.pc_o, bus.br_pending_o, bus.preif_to_if_valid_o);
        end
        tick();
        rst_n = 1'b1;
        bus.if_allowin_i = 1'b1;
        tick();
        checks++;
        if (bus.pc_o !== RST_PC || bus.preif_to_if_valid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rereset_fetch got %h/valid %b want 1c000000/1", bus.pc_o, bus.preif_to_if_valid_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.if_allowin_i = 1'b0;
        clear_inputs();
        test_reset();
        test_branch_accept();
        test_branch_stall();
        test_exception();
        test_ertn();
        test_wrap();
        test_adef();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
